// File: rtl/hum_pkg.sv
// Shared humidity constants and types for the datapath and the humidity control logic.
package hum_pkg;

    localparam int HUM_W        = 7;
    localparam int HUM_FULL     = 100;
    localparam int HUM_MIN_DEF  = 30;
    localparam int HUM_MAX_DEF  = 70;
    localparam int HUM_DEF_DEF  = 50;

    typedef logic [HUM_W-1:0] hum_t;

    // Raw sensor samples can exceed full scale; clamp before they reach the register.
    function automatic hum_t hum_clip(input logic [7:0] raw);
        if (raw > 8'(HUM_FULL))
            return hum_t'(HUM_FULL);
        return raw[HUM_W-1:0];
    endfunction

endpackage

// File: rtl/hum_tick_counter.sv
// Free-running 1 s tick counter; terminal is a pure decode of the count register.
module hum_tick_counter #(
    parameter int TICKS = 100_000_000
) (
    input  logic pclk,
    input  logic preset,
    input  logic en,
    input  logic clr,
    output logic terminal
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge pclk) begin
        if (preset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign terminal = (cnt_q == LAST);

endmodule

// File: rtl/hum_datapath.sv
// Humidity register with sensor load and saturating steps, threshold decodes and 1 s tick.
module hum_datapath
    import hum_pkg::*;
#(
    parameter int TICKS_1S = 100_000_000,
    parameter int HUM_MIN  = HUM_MIN_DEF,
    parameter int HUM_MAX  = HUM_MAX_DEF,
    parameter int HUM_DEF  = HUM_DEF_DEF
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       sensor_valid,
    input  logic [7:0] sensor_hum,
    input  logic       hum_inc_en,
    input  logic       hum_dec_en,
    input  logic       hum_counter_en,
    input  logic       hum_counter_clr,
    output logic [6:0] hum_value,
    output logic       crossed_min_hum,
    output logic       crossed_max_hum,
    output logic       default_hum,
    output logic       count_eq_1s
);

    if (!(HUM_MIN < HUM_DEF && HUM_DEF < HUM_MAX && HUM_MAX <= HUM_FULL)) begin : g_bad_params
        $error("hum_datapath: thresholds must satisfy HUM_MIN < HUM_DEF < HUM_MAX <= 100");
    end

    hum_t hum_q, hum_d;

    always_comb begin
        hum_d = hum_q;
        if (sensor_valid)
            hum_d = hum_clip(sensor_hum);
        else if (hum_inc_en && !hum_dec_en && hum_q != hum_t'(HUM_FULL))
            hum_d = hum_q + hum_t'(1);
        else if (hum_dec_en && !hum_inc_en && hum_q != '0)
            hum_d = hum_q - hum_t'(1);
    end

    always_ff @(posedge pclk) begin
        if (preset)
            hum_q <= hum_t'(HUM_DEF);
        else
            hum_q <= hum_d;
    end

    // Flags decode the register only, so they never glitch on input changes.
    assign hum_value       = hum_q;
    assign crossed_min_hum = (hum_q < hum_t'(HUM_MIN));
    assign crossed_max_hum = (hum_q > hum_t'(HUM_MAX));
    assign default_hum     = (hum_q == hum_t'(HUM_DEF));

    hum_tick_counter #(
        .TICKS (TICKS_1S)
    ) u_tick (
        .pclk     (pclk),
        .preset   (preset),
        .en       (hum_counter_en),
        .clr      (hum_counter_clr),
        .terminal (count_eq_1s)
    );

endmodule

// File: doc/hum_datapath.md
HUM_DATAPATH -- requirements
Module: hum_datapath

Interface
REQ-001 SHALL have parameter TICKS_1S, default 100_000_000; pclk cycles per 1 s tick (bench uses 10).
REQ-002 SHALL have parameter HUM_MIN, default 30; lower humidity threshold, %RH.
REQ-003 SHALL have parameter HUM_MAX, default 70; upper humidity threshold, %RH.
REQ-004 SHALL have parameter HUM_DEF, default 50; default humidity set point, %RH.
REQ-005 SHALL have port pclk, input, 1; single clock, all logic on rising edge.
REQ-006 SHALL have port preset, input, 1; reset, synchronous, active-high.
REQ-007 SHALL have port sensor_valid, input, 1; qualifies sensor_hum for one cycle.
REQ-008 SHALL have port sensor_hum, input, 8; raw humidity sample, %RH.
REQ-009 SHALL have port hum_inc_en, input, 1; +1 step request from the control FSM.
REQ-010 SHALL have port hum_dec_en, input, 1; -1 step request from the control FSM.
REQ-011 SHALL have port hum_counter_en, input, 1; 1 s counter enable.
REQ-012 SHALL have port hum_counter_clr, input, 1; 1 s counter clear.
REQ-013 SHALL have port hum_value, output, 7; current humidity register, 0..100.
REQ-014 SHALL have port crossed_min_hum, output, 1; hum_value < HUM_MIN.
REQ-015 SHALL have port crossed_max_hum, output, 1; hum_value > HUM_MAX.
REQ-016 SHALL have port default_hum, output, 1; hum_value == HUM_DEF.
REQ-017 SHALL have port count_eq_1s, output, 1; 1 s counter at terminal count.

Function
REQ-018 SHALL update hum_value once per cycle, in priority order: sensor_valid load > step > hold.
REQ-019 SHALL load min(sensor_hum, 100) when sensor_valid=1, ignoring hum_inc_en and hum_dec_en in that cycle.
REQ-020 SHALL apply +1 on hum_inc_en=1 with hum_dec_en=0, saturating at 100 (no wrap to 0).
REQ-021 SHALL apply -1 on hum_dec_en=1 with hum_inc_en=0, saturating at 0 (no wrap to 100).
REQ-022 SHALL hold hum_value when hum_inc_en and hum_dec_en are both 1.
REQ-023 SHALL decode crossed_min_hum, crossed_max_hum and default_hum combinationally from the hum_value register only: 1-cycle latency from a load/step, no glitch path from inputs.
REQ-024 SHALL use a 1 s counter of width $clog2(TICKS_1S): clr -> 0 (clr wins over en); else en and count==TICKS_1S-1 -> 0; else en -> +1; else hold.
REQ-025 SHALL assert count_eq_1s = (count == TICKS_1S-1), registered-state decode, independent of en.
REQ-026 SHALL produce exactly one count_eq_1s cycle per TICKS_1S enabled cycles when en is held and clr is driven only by count_eq_1s.
REQ-027 SHALL give no sensor_valid handshake: every valid cycle is consumed; back-to-back samples load on consecutive cycles.
REQ-028 SHALL require HUM_MIN < HUM_DEF < HUM_MAX <= 100 (elaboration-time assertion).

Reset
REQ-029 SHALL, on preset=1 at a pclk edge, set hum_value=HUM_DEF and count=0, giving default_hum=1, crossed_min_hum=0, crossed_max_hum=0, count_eq_1s=0 from the next cycle.
REQ-030 SHALL give reset priority over sensor_valid, steps, en and clr, including mid-count and mid-step.

Structure
REQ-031 SHALL place HUM_W=7, HUM_FULL=100 and the default HUM_MIN/HUM_MAX/HUM_DEF values in package hum_pkg, shared with hum_ctl logic.
REQ-032 SHALL implement the 1 s counter as sub-module hum_tick_counter (params TICKS; ports pclk, preset, en, clr, terminal).

Verification (TICKS_1S=10)
REQ-033 SHALL check: reset -> hum_value=50, default_hum=1, count_eq_1s=0.
REQ-034 SHALL check: sensor_valid with sensor_hum=20 -> next cycle hum_value=20, crossed_min_hum=1; then sensor_hum=200 -> hum_value=100, crossed_max_hum=1.
REQ-035 SHALL check: hum_value=100 with hum_inc_en for 3 cycles -> stays 100; hum_value=0 with hum_dec_en -> stays 0; inc and dec together at 45 -> 45.
REQ-036 SHALL check: sensor_valid(60) with hum_inc_en in the same cycle -> 60, not 61.
REQ-037 SHALL check: en held, clr tied to count_eq_1s -> count_eq_1s pulses on cycles 10, 20, 30; clr+en in one cycle -> count 0.
REQ-038 SHALL check: closed loop with the control FSM, sensor 25, dry state, inc on each tick -> hum_value reaches 50 after 25 ticks, default_hum=1, then no further steps.
